axi4l_cfg_seq: RTL and testbench
================================

// Module: axi4l_cfg_seq
// PURPOSE
//  Table-driven configuration sequencer: an AXI4-Lite master that programs a cheby-generated
//  register bank (e.g. areg/breg at 0x0/0x4) after start, walking a synchronous table of
//  WRITE / VERIFY / POLL / END entries, one outstanding transaction at a time.
//  Sits between boot/control logic and the register bank's AXI4-Lite slave port.
// PARAMETERS
//  ADDR_W    3    AXI address width (byte address; word-aligned entries only)
//  TBL_AW    4    table index width; table depth 2**TBL_AW
//  POLL_MAX  255  max reads per POLL entry before timeout (must be >= 1)
// PORTS
//  aclk      in   1          clock, all logic rising-edge
//  areset    in   1          reset, asynchronous, active-high
//  start     in   1          1-cycle pulse; begin sequence at index 0 (ignored while busy)
//  busy      out  1          high from cycle after accepted start until done pulse
//  done      out  1          1-cycle pulse at end of sequence (success or error)
//  err       out  1          sequence ended in error; held until next accepted start
//  err_code  out  2          0 none, 1 bus resp != OKAY, 2 VERIFY mismatch, 3 POLL timeout
//  tbl_addr  out  TBL_AW     table index; after error holds index of failing entry
//  tbl_data  in   34+ADDR_W  {op[1:0], addr[ADDR_W-1:0], data[31:0]}, valid 1 cycle after tbl_addr
//  awvalid awready awaddr[ADDR_W]  out/in/out  AW channel
//  wvalid wready wdata[32] wstrb[4] out/in/out/out W channel; wstrb always 4'hF
//  bvalid bready bresp[2]          in/out/in   B channel
//  arvalid arready araddr[ADDR_W]  out/in/out  AR channel
//  rvalid rready rdata[32] rresp[2] in/out/in/in R channel
//  (awprot/arprot not generated; tie 3'b000 at integration)
// BEHAVIOUR
//  Reset: all valids/readys 0, busy/done/err 0, err_code 0, tbl_addr 0, FSM IDLE; takes effect
//   immediately mid-transaction (slave is reset by the same reset).
//  Ops: 00 END, 01 WRITE addr<=data, 10 VERIFY read addr, require rdata==data,
//   11 POLL read addr until rdata==data, at most POLL_MAX reads.
//  FSM: IDLE -start-> FETCH (drive tbl_addr, 1 cycle) -> DECODE (register entry)
//   -> WRITE: WADDR (awvalid&wvalid both set; each cleared independently on its ready) -> WRESP
//      (bready=1 until bvalid) ; read ops: RADDR (arvalid until arready) -> RRESP (rready=1 until rvalid)
//   -> CHECK -> next index FETCH | retry RADDR (POLL) | FIN.  END -> FIN.  FIN: done=1, -> IDLE.
//  AXI rules: valid never dropped before ready; addr/data stable while valid; awready/wready may
//   arrive in either order or same cycle; bready/rready held 1 in response states only.
//  Errors: bresp/rresp != 2'b00 -> code 1 (checked before data compare); VERIFY mismatch -> 2;
//   POLL_MAX reads without match -> 3; on error go FIN, no further entries, tbl_addr frozen.
//  Poll counter: 8+ bit, cleared in DECODE, incremented per completed read; match on read N<=POLL_MAX ok.
//  Table end: entry at index 2**TBL_AW-1 completes -> FIN with err=0 (no wrap to 0).
//  Start during busy ignored; start same cycle as done ignored (IDLE entered next cycle).
//  Latency: zero-wait slave -> WRITE entry 4 cycles + slave B latency; done 1 cycle after END decode.
// STRUCTURE
//  axi4l_cfg_seq_pkg: op encodings, err codes, state enum, entry field offsets/widths.
//  One sub-module: axi4l_single_xfer (one write or read transaction, req/ack + resp/rdata out);
//   sequencer FSM, poll counter and compare stay in axi4l_cfg_seq.
// TESTING (bench: this block + register bank slave, reset via areset)
//  Table {W 0x0 DEADBEEF, W 0x4 12345678, V 0x0 DEADBEEF, V 0x4 12345678, END}; start ->
//   areg_o=DEADBEEF, breg_o=12345678, one done pulse, err=0, busy low after done.
//  Entry 2 V 0x0 DEADBEEE -> done, err=1, err_code=2, tbl_addr=2, no AR issued for entry 3.
//  POLL_MAX=4, P 0x4 00000001 with breg=0 -> exactly 4 AR handshakes, err_code=3, tbl_addr=0.
//  BFM slave bresp=2'b10 on first write -> err_code=1, tbl_addr=0; next start clears err.
//  BFM awready low 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles,
//   awaddr/wdata stable; 16 WRITE entries w/o END -> done after index 15, err=0.
//  areset mid-WRESP -> all outputs 0 next edge; start then rerun full table correctly; start while busy ignored.

Source files
------------

// File: rtl/axi4l_cfg_seq_pkg.sv
// Shared encodings for the table-driven AXI4-Lite configuration sequencer.
// Table entry layout is {op, addr, data} with data in the low 32 bits.
package axi4l_cfg_seq_pkg;

    typedef enum logic [1:0] {
        OP_END    = 2'b00,
        OP_WRITE  = 2'b01,
        OP_VERIFY = 2'b10,
        OP_POLL   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RESP    = 2'd1,
        ERR_VERIFY  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_XFER, S_CHECK, S_FIN
    } seq_state_t;

    typedef enum logic [2:0] {
        X_IDLE, X_WADDR, X_WRESP, X_RADDR, X_RRESP
    } xfer_state_t;

    localparam int DATA_W = 32;
    localparam int OP_W   = 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi4l_single_xfer.sv
// One AXI4-Lite write or read per req_vld; ack_vld pulses on the B/R handshake.
// Latency: zero-wait slave gives AW/W or AR 1 cycle after req, ack with the response beat.
// Backpressure: valids held until ready (AW and W retire independently); bready/rready only in response states.
module axi4l_single_xfer
    import axi4l_cfg_seq_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              req_vld,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_dat,
    output logic              ack_vld,
    output logic [1:0]        ack_resp,
    output logic [31:0]       ack_dat,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp
);

    xfer_state_t       state_q, state_d;
    logic              aw_pend_q, w_pend_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdat_q;
    logic              aw_done, w_done;

    assign aw_done = !aw_pend_q || awready;
    assign w_done  = !w_pend_q || wready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= X_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            X_IDLE:  if (req_vld) state_d = req_we ? X_WADDR : X_RADDR;
            X_WADDR: if (aw_done && w_done) state_d = X_WRESP;
            X_WRESP: if (bvalid) state_d = X_IDLE;
            X_RADDR: if (arready) state_d = X_RRESP;
            X_RRESP: if (rvalid) state_d = X_IDLE;
            default: state_d = X_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
        end else if (state_q == X_IDLE && req_vld) begin
            aw_pend_q <= req_we;
            w_pend_q  <= req_we;
            addr_q    <= req_addr;
            wdat_q    <= req_dat;
        end else begin
            if (awready) aw_pend_q <= 1'b0;
            if (wready)  w_pend_q  <= 1'b0;
        end
    end

    assign awvalid = aw_pend_q;
    assign wvalid  = w_pend_q;
    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign wdata   = wdat_q;
    assign wstrb   = 4'hF;
    assign arvalid = (state_q == X_RADDR);
    assign bready  = (state_q == X_WRESP);
    assign rready  = (state_q == X_RRESP);

    assign ack_vld  = (state_q == X_WRESP && bvalid) || (state_q == X_RRESP && rvalid);
    assign ack_resp = (state_q == X_WRESP) ? bresp : rresp;
    assign ack_dat  = rdata;

endmodule

// File: rtl/axi4l_cfg_seq.sv
// Table-driven AXI4-Lite config sequencer: WRITE/VERIFY/POLL/END entries, one transaction outstanding.
// Latency: fetch+decode 2 cycles per entry, then the bus transaction, then 1 check cycle; done 1 cycle after END.
// Backpressure: waits indefinitely on slave ready/response; start ignored while busy.
module axi4l_cfg_seq
    import axi4l_cfg_seq_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int TBL_AW   = 4,
    parameter int POLL_MAX = 255
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [TBL_AW-1:0]      tbl_addr,
    input  logic [33+ADDR_W:0]     tbl_data,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [ADDR_W-1:0]      awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [31:0]            wdata,
    output logic [3:0]             wstrb,
    input  logic                   bvalid,
    output logic                   bready,
    input  logic [1:0]             bresp,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [ADDR_W-1:0]      araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [31:0]            rdata,
    input  logic [1:0]             rresp
);

    localparam int OP_LSB   = DATA_W + ADDR_W;
    localparam int PCNT_RAW = $clog2(POLL_MAX + 1);
    localparam int PCNT_W   = (PCNT_RAW > 8) ? PCNT_RAW : 8;

    seq_state_t        state_q, state_d;
    logic [TBL_AW-1:0] tbl_addr_q;
    op_t               op_q;
    logic [ADDR_W-1:0] ent_addr_q;
    logic [31:0]       ent_dat_q;
    logic [PCNT_W-1:0] poll_cnt_q;
    logic [1:0]        resp_q;
    logic [31:0]       rdat_q;
    logic              err_q;
    err_t              err_code_q;

    op_t               tbl_op;
    logic              x_req, x_we, x_ack;
    logic [ADDR_W-1:0] x_addr;
    logic [31:0]       x_dat, x_rdat;
    logic [1:0]        x_resp;
    logic              adv, fail;
    err_t              fail_code;

    assign tbl_op = op_t'(tbl_data[OP_LSB +: OP_W]);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        x_req     = 1'b0;
        adv       = 1'b0;
        fail      = 1'b0;
        fail_code = ERR_NONE;
        // DECODE issues straight from the table word; POLL retries reuse the registered entry
        x_we   = (state_q == S_DECODE) ? (tbl_op == OP_WRITE) : (op_q == OP_WRITE);
        x_addr = (state_q == S_DECODE) ? tbl_data[DATA_W +: ADDR_W] : ent_addr_q;
        x_dat  = (state_q == S_DECODE) ? tbl_data[DATA_W-1:0] : ent_dat_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (tbl_op == OP_END) begin
                    state_d = S_FIN;
                end else begin
                    x_req   = 1'b1;
                    state_d = S_XFER;
                end
            end
            S_XFER:   if (x_ack) state_d = S_CHECK;
            S_CHECK: begin
                if (resp_q != RESP_OKAY) begin
                    fail      = 1'b1;
                    fail_code = ERR_RESP;
                end else if (op_q == OP_VERIFY && rdat_q != ent_dat_q) begin
                    fail      = 1'b1;
                    fail_code = ERR_VERIFY;
                end else if (op_q == OP_POLL && rdat_q != ent_dat_q) begin
                    if (poll_cnt_q >= PCNT_W'(POLL_MAX)) begin
                        fail      = 1'b1;
                        fail_code = ERR_TIMEOUT;
                    end else begin
                        x_req   = 1'b1;
                        state_d = S_XFER;
                    end
                end
                if (fail) begin
                    state_d = S_FIN;
                end else if (!x_req) begin
                    if (&tbl_addr_q) begin
                        state_d = S_FIN;
                    end else begin
                        adv     = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tbl_addr_q <= '0;
            op_q       <= OP_END;
            ent_addr_q <= '0;
            ent_dat_q  <= '0;
            poll_cnt_q <= '0;
            resp_q     <= '0;
            rdat_q     <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (state_q == S_IDLE && start) begin
                tbl_addr_q <= '0;
                err_q      <= 1'b0;
                err_code_q <= ERR_NONE;
            end
            if (state_q == S_DECODE) begin
                op_q       <= tbl_op;
                ent_addr_q <= tbl_data[DATA_W +: ADDR_W];
                ent_dat_q  <= tbl_data[DATA_W-1:0];
                poll_cnt_q <= '0;
            end
            if (state_q == S_XFER && x_ack) begin
                resp_q <= x_resp;
                rdat_q <= x_rdat;
                if (op_q != OP_WRITE) poll_cnt_q <= poll_cnt_q + 1'b1;
            end
            if (adv) tbl_addr_q <= tbl_addr_q + 1'b1;
            if (fail) begin
                err_q      <= 1'b1;
                err_code_q <= fail_code;
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);
    assign err      = err_q;
    assign err_code = err_code_q;
    assign tbl_addr = tbl_addr_q;

    axi4l_single_xfer #(.ADDR_W(ADDR_W)) u_xfer (
        .aclk     (aclk),
        .areset   (areset),
        .req_vld  (x_req),
        .req_we   (x_we),
        .req_addr (x_addr),
        .req_dat  (x_dat),
        .ack_vld  (x_ack),
        .ack_resp (x_resp),
        .ack_dat  (x_rdat),
        .awvalid  (awvalid),
        .awready  (awready),
        .awaddr   (awaddr),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .bvalid   (bvalid),
        .bready   (bready),
        .bresp    (bresp),
        .arvalid  (arvalid),
        .arready  (arready),
        .araddr   (araddr),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .rresp    (rresp)
    );

endmodule

// File: tb/tb_axi4l_cfg_seq.sv
// Directed bench for axi4l_cfg_seq against a two-register AXI4-Lite slave model (areg 0x0, breg 0x4).
module tb_axi4l_cfg_seq;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [3:0]  tbl_addr;
    logic [36:0] tbl_data = '0;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [2:0]  awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_tests = 0;
    int n_fail  = 0;

    axi4l_cfg_seq #(.ADDR_W(3), .TBL_AW(4), .POLL_MAX(4)) dut (
        .aclk(aclk), .areset(areset), .start(start), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    initial forever #5 aclk = ~aclk;

    // synchronous table ROM
    logic [36:0] tbl [16];
    always @(posedge aclk) tbl_data <= tbl[tbl_addr];

    // slave model
    logic [31:0] areg, breg, w_d;
    logic [2:0]  aw_a;
    logic        aw_got, w_got;
    int aw_wait = 0, aw_stall = 0, err_at = -1, wr_cnt = 0, ar_cnt = 0;

    assign awready = awvalid && (aw_wait >= aw_stall);
    assign wready  = 1'b1;
    assign arready = 1'b1;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; aw_wait <= 0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            areg <= '0; breg <= '0;
        end else begin
            if (awvalid && !awready) aw_wait <= aw_wait + 1;
            else if (awvalid && awready) aw_wait <= 0;
            if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; end
            if (wvalid && wready) begin w_got <= 1'b1; w_d <= wdata; end
            if (aw_got && w_got && !bvalid) begin
                aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b1;
                wr_cnt <= wr_cnt + 1;
                if (wr_cnt == err_at) bresp <= 2'b10;
                else begin
                    bresp <= 2'b00;
                    if (aw_a[2]) breg <= w_d; else areg <= w_d;
                end
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1; rresp <= 2'b00;
                rdata  <= araddr[2] ? breg : areg;
                ar_cnt <= ar_cnt + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // protocol monitor: valid held and payload stable until handshake
    int aw_cyc = 0, w_cyc = 0, done_cnt = 0, viol = 0;
    logic aw_h = 1'b0, w_h = 1'b0, ar_h = 1'b0;
    logic [2:0] aw_ha, ar_ha;
    logic [31:0] w_hd;
    always @(posedge aclk) begin
        if (!areset) begin
            if (awvalid) aw_cyc <= aw_cyc + 1;
            if (wvalid)  w_cyc  <= w_cyc + 1;
            if (done)    done_cnt <= done_cnt + 1;
            if ((aw_h && (!awvalid || awaddr !== aw_ha)) ||
                (w_h && (!wvalid || wdata !== w_hd || wstrb !== 4'hF)) ||
                (ar_h && (!arvalid || araddr !== ar_ha)))
                viol <= viol + 1;
        end
        aw_h <= !areset && awvalid && !awready;
        w_h  <= !areset && wvalid && !wready;
        ar_h <= !areset && arvalid && !arready;
        aw_ha <= awaddr; w_hd <= wdata; ar_ha <= araddr;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] ent(input logic [1:0] op, input logic [2:0] a, input logic [31:0] d);
        return {op, a, d};
    endfunction

    // start pulse, optional second start while busy, optional start on the done cycle
    task automatic run(input bit start_on_done, input int restart_at);
        int n;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("err_cleared_on_start", {63'd0, err}, 64'd0);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            start = (n == restart_at);
            @(negedge aclk);
            n++;
        end
        start = 1'b0;
        chk("done_seen", {63'd0, done}, 64'd1);
        if (start_on_done) start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk("busy_after_done", {63'd0, busy}, 64'd0);
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 16; i++) tbl[i] = '0;
    endtask

    int ar0, wr0, dn0, aw0, w0, n;

    initial begin
        clear_tbl();
        repeat (3) @(negedge aclk);
        chk("reset_outputs", {48'd0, awvalid, wvalid, arvalid, bready, rready, busy, done, err, err_code, tbl_addr},
            64'd0);
        chk("reset_payload", {29'd0, awaddr, wdata}, 64'd0);
        areset = 1'b0;
        @(negedge aclk);

        // basic write/verify table, start on the done cycle must be ignored
        tbl[0] = ent(2'b01, 3'h0, 32'hDEADBEEF);
        tbl[1] = ent(2'b01, 3'h4, 32'h12345678);
        tbl[2] = ent(2'b10, 3'h0, 32'hDEADBEEF);
        tbl[3] = ent(2'b10, 3'h4, 32'h12345678);
        tbl[4] = '0;
        ar0 = ar_cnt; dn0 = done_cnt;
        run(1'b1, -1);
        @(negedge aclk);
        chk("start_on_done_ignored", {63'd0, busy}, 64'd0);
        chk("t1_err", {61'd0, err, err_code}, 64'd0);
        chk("t1_areg", {32'd0, areg}, 64'hDEADBEEF);
        chk("t1_breg", {32'd0, breg}, 64'h12345678);
        chk("t1_done_pulses", done_cnt - dn0, 64'd1);
        chk("t1_ar_count", ar_cnt - ar0, 64'd2);
        chk("t1_tbl_addr", {60'd0, tbl_addr}, 64'd4);

        // verify mismatch at entry 2
        tbl[2] = ent(2'b10, 3'h0, 32'hDEADBEEE);
        ar0 = ar_cnt;
        run(1'b0, -1);
        chk("t2_err_code", {61'd0, err, err_code}, {61'd0, 1'b1, 2'd2});
        chk("t2_tbl_addr", {60'd0, tbl_addr}, 64'd2);
        chk("t2_ar_count", ar_cnt - ar0, 64'd1);

        // poll timeout: breg cleared by reset, 4 reads then code 3
        areset = 1'b1; @(negedge aclk); areset = 1'b0; @(negedge aclk);
        clear_tbl();
        tbl[0] = ent(2'b11, 3'h4, 32'h00000001);
        ar0 = ar_cnt;
        run(1'b0, -1);
        chk("t3_err_code", {61'd0, err, err_code}, {61'd0, 1'b1, 2'd3});
        chk("t3_tbl_addr", {60'd0, tbl_addr}, 64'd0);
        chk("t3_ar_count", ar_cnt - ar0, 64'd4);

        // poll matching on first read
        tbl[0] = ent(2'b11, 3'h0, 32'h00000000);
        ar0 = ar_cnt;
        run(1'b0, -1);
        chk("t3b_err", {61'd0, err, err_code}, 64'd0);
        chk("t3b_ar_count", ar_cnt - ar0, 64'd1);
        chk("t3b_tbl_addr", {60'd0, tbl_addr}, 64'd1);

        // bus error on first write, then clean rerun
        clear_tbl();
        tbl[0] = ent(2'b01, 3'h0, 32'h11111111);
        tbl[1] = ent(2'b01, 3'h4, 32'h22222222);
        err_at = wr_cnt;
        run(1'b0, -1);
        chk("t4_err_code", {61'd0, err, err_code}, {61'd0, 1'b1, 2'd1});
        chk("t4_tbl_addr", {60'd0, tbl_addr}, 64'd0);
        chk("t4_areg_unwritten", {32'd0, areg}, 64'd0);
        err_at = -1;
        run(1'b0, -1);
        chk("t4_rerun_err", {61'd0, err, err_code}, 64'd0);
        chk("t4_rerun_breg", {32'd0, breg}, 64'h22222222);

        // 16 writes without END, awready stalled 3 cycles
        for (int i = 0; i < 16; i++) tbl[i] = ent(2'b01, (i % 2 == 0) ? 3'h0 : 3'h4, 32'h10000000 + i);
        aw_stall = 3;
        aw0 = aw_cyc; w0 = w_cyc;
        run(1'b0, -1);
        aw_stall = 0;
        chk("t5_err", {61'd0, err, err_code}, 64'd0);
        chk("t5_tbl_addr", {60'd0, tbl_addr}, 64'd15);
        chk("t5_areg", {32'd0, areg}, 64'h1000000E);
        chk("t5_breg", {32'd0, breg}, 64'h1000000F);
        chk("t5_awvalid_cycles", aw_cyc - aw0, 64'd64);
        chk("t5_wvalid_cycles", w_cyc - w0, 64'd16);
        chk("protocol_violations", viol, 64'd0);

        // reset while waiting for B, then full rerun with a start while busy
        clear_tbl();
        tbl[0] = ent(2'b01, 3'h0, 32'hDEADBEEF);
        tbl[1] = ent(2'b01, 3'h4, 32'h12345678);
        tbl[2] = ent(2'b10, 3'h0, 32'hDEADBEEF);
        tbl[3] = ent(2'b10, 3'h4, 32'h12345678);
        start = 1'b1; @(negedge aclk); start = 1'b0;
        n = 0;
        while (bready !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
        chk("t6_reached_wresp", {63'd0, bready}, 64'd1);
        areset = 1'b1;
        @(posedge aclk); #1;
        chk("t6_reset_outputs", {48'd0, awvalid, wvalid, arvalid, bready, rready, busy, done, err, err_code, tbl_addr},
            64'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        chk("t6_slave_cleared", {32'd0, areg}, 64'd0);
        ar0 = ar_cnt; wr0 = wr_cnt; dn0 = done_cnt;
        run(1'b0, 3);
        chk("t6_err", {61'd0, err, err_code}, 64'd0);
        chk("t6_areg", {32'd0, areg}, 64'hDEADBEEF);
        chk("t6_breg", {32'd0, breg}, 64'h12345678);
        chk("t6_writes", wr_cnt - wr0, 64'd2);
        chk("t6_reads", ar_cnt - ar0, 64'd2);
        chk("t6_done_pulses", done_cnt - dn0, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
